// File: rtl/data_ram_pkg.sv
// ----------------------------------------------------------------------------
// data_ram_pkg
// Shared definitions for the data RAM slice: default address map, read-FSM
// state encoding, wait-counter width and small datapath helpers.
// No ports (package).
// ----------------------------------------------------------------------------
package data_ram_pkg;

    // Default placement and size of the RAM in the byte address space.
    localparam logic [63:0] DEF_BASE_ADDR = 64'h0000_0000_8000_0000;
    localparam int unsigned DEF_DEPTH     = 4096;
    localparam int unsigned DEF_RD_LAT    = 2;

    // Width of the read wait counter; bounds RD_LAT to 1..7.
    localparam int unsigned CNT_W = 3;

    typedef logic [63:0] word_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } rd_state_e;

    // Bit-granular merge: mask bits set take the new word, others keep old.
    function automatic word_t mask_merge(input word_t old_word,
                                         input word_t new_word,
                                         input word_t mask);
        return (old_word & ~mask) | (new_word & mask);
    endfunction

    // Range test written as an offset compare so base+span never overflows.
    function automatic logic addr_in_range(input logic [63:0] addr,
                                           input logic [63:0] base,
                                           input logic [63:0] span);
        return (addr >= base) && ((addr - base) < span);
    endfunction

endpackage

// File: rtl/data_ram_if.sv
// ----------------------------------------------------------------------------
// data_ram_if
// Read/write bus between a requester and data_ram. Signal suffixes are from
// the RAM's point of view (_i driven by the requester, _o by the RAM).
//   ram_ren_i / ram_raddr_i          read request, held until ram_ready_o
//   ram_rdata_o                      registered read data
//   ram_wen_i / ram_waddr_i /
//   ram_wdata_i / ram_wmask_i        single-cycle masked write
//   ram_ready_o                      read complete or no read pending
//   ram_err_o                        access-fault pulse
// Modports: master (requester), slave (RAM).
// ----------------------------------------------------------------------------
interface data_ram_if;
    import data_ram_pkg::*;

    logic  ram_ren_i;
    logic  [63:0] ram_raddr_i;
    word_t ram_rdata_o;
    logic  ram_wen_i;
    logic  [63:0] ram_waddr_i;
    word_t ram_wdata_i;
    word_t ram_wmask_i;
    logic  ram_ready_o;
    logic  ram_err_o;

    modport master (
        output ram_ren_i, ram_raddr_i,
        output ram_wen_i, ram_waddr_i, ram_wdata_i, ram_wmask_i,
        input  ram_rdata_o, ram_ready_o, ram_err_o
    );

    modport slave (
        input  ram_ren_i, ram_raddr_i,
        input  ram_wen_i, ram_waddr_i, ram_wdata_i, ram_wmask_i,
        output ram_rdata_o, ram_ready_o, ram_err_o
    );

endinterface

// File: rtl/data_ram_array.sv
// ----------------------------------------------------------------------------
// ram_array
// Doubleword storage with a masked write port and a registered read port
// that forwards a same-edge write to the index being loaded.
//   clk, rst      clock, synchronous active-low reset (read register only)
//   we_i          write enable (already range-checked and reset-gated)
//   widx_i        write index
//   wdata_i       write data
//   wmask_i       bit-granular write mask
//   ld_i          load the read register this edge
//   ld_zero_i     load zero instead of array data (faulting read)
//   ridx_i        read index
//   rdata_o       registered read data, holds when ld_i is low
// ----------------------------------------------------------------------------
module ram_array
    import data_ram_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we_i,
    input  logic [AW-1:0] widx_i,
    input  word_t         wdata_i,
    input  word_t         wmask_i,
    input  logic          ld_i,
    input  logic          ld_zero_i,
    input  logic [AW-1:0] ridx_i,
    output word_t         rdata_o
);

    word_t mem_q [DEPTH];
    word_t rd_word;
    word_t rdata_q;
    word_t rdata_d;

    // NOTE: the storage array has no reset -- clearing thousands of words
    // would need a reset port per word; contents persist across rst.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[widx_i] <= mask_merge(mem_q[widx_i], wdata_i, wmask_i);
        end
    end

    // NOTE: every variable gets a default at the top of the always_comb so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        rd_word = mem_q[ridx_i];
        // The array is updated on the same edge, so the old word plus the
        // incoming masked write gives the value the read must observe.
        if (we_i && (widx_i == ridx_i)) begin
            rd_word = mask_merge(rd_word, wdata_i, wmask_i);
        end
        rdata_d = rdata_q;
        if (ld_i) begin
            rdata_d = ld_zero_i ? '0 : rd_word;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_ram.sv
// ----------------------------------------------------------------------------
// data_ram
// 64-bit data RAM with fixed read latency, bit-masked single-cycle writes,
// address-range checking and an access-fault pulse.
//   clk   clock, all state on rising edge
//   rst   synchronous active-low reset
//   bus   data_ram_if.slave: read request/data/ready, masked write, error
// Parameters: BASE_ADDR (byte address of word 0), DEPTH (words, power of
// two), RD_LAT (read latency in cycles, 1..7).
// ----------------------------------------------------------------------------
module data_ram
    import data_ram_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR = DEF_BASE_ADDR,
    parameter int unsigned DEPTH     = DEF_DEPTH,
    parameter int unsigned RD_LAT    = DEF_RD_LAT
) (
    input  logic      clk,
    input  logic      rst,
    data_ram_if.slave bus
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam logic [63:0] SPAN = 64'(DEPTH) << 3;
    // Cycles spent in WAIT after the IDLE request cycle, minus one.
    localparam logic [CNT_W-1:0] CNT_INIT =
        (RD_LAT > 1) ? CNT_W'(RD_LAT - 2) : '0;

    function automatic logic [AW-1:0] addr_idx(input logic [63:0] addr);
        return AW'((addr - BASE_ADDR) >> 3);
    endfunction

    rd_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]    ridx_q, ridx_d;
    logic             roor_q, roor_d;
    logic             err_q, err_d;

    logic             r_in_range;
    logic [AW-1:0]    r_idx;
    logic             w_in_range;
    logic [AW-1:0]    w_idx;
    logic             we;
    logic             wr_err;
    logic             rd_load;
    logic [AW-1:0]    ld_idx;
    logic             ld_oor;

    // ---------------- address decode ----------------
    assign r_in_range = addr_in_range(bus.ram_raddr_i, BASE_ADDR, SPAN);
    assign r_idx      = addr_idx(bus.ram_raddr_i);
    assign w_in_range = addr_in_range(bus.ram_waddr_i, BASE_ADDR, SPAN);
    assign w_idx      = addr_idx(bus.ram_waddr_i);

    // Writes are ignored while reset is asserted.
    assign we     = rst & bus.ram_wen_i & w_in_range;
    assign wr_err = bus.ram_wen_i & ~w_in_range;

    // With RD_LAT=1 the load happens on the edge leaving IDLE, before the
    // request has been captured, so the live address is used there.
    assign ld_idx = (state_q == ST_IDLE) ? r_idx : ridx_q;
    assign ld_oor = (state_q == ST_IDLE) ? ~r_in_range : roor_q;

    // ---------------- read FSM ----------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ridx_d  = ridx_q;
        roor_d  = roor_q;
        rd_load = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.ram_ren_i) begin
                    ridx_d = r_idx;
                    roor_d = ~r_in_range;
                    if (RD_LAT > 1) begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d = ST_DONE;
                        rd_load = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (!bus.ram_ren_i) begin
                    // Requester withdrew: drop the read, keep rdata.
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = ST_DONE;
                    rd_load = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Read fault lands in the DONE cycle, write fault in the cycle after the
    // write; both are registered on the same edge, so they merge into one.
    assign err_d = (rd_load & ld_oor) | wr_err;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ridx_q  <= '0;
            roor_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ridx_q  <= ridx_d;
            roor_q  <= roor_d;
            err_q   <= err_d;
        end
    end

    // ---------------- storage ----------------
    ram_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk       (clk),
        .rst       (rst),
        .we_i      (we),
        .widx_i    (w_idx),
        .wdata_i   (bus.ram_wdata_i),
        .wmask_i   (bus.ram_wmask_i),
        .ld_i      (rd_load),
        .ld_zero_i (ld_oor),
        .ridx_i    (ld_idx),
        .rdata_o   (bus.ram_rdata_o)
    );

    // ---------------- outputs ----------------
    assign bus.ram_ready_o = (state_q == ST_DONE) |
                             ((state_q == ST_IDLE) & ~bus.ram_ren_i);
    assign bus.ram_err_o   = err_q;

endmodule

// File: tb/tb_data_ram.sv
// ----------------------------------------------------------------------------
// tb_data_ram
// Self-checking bench for data_ram (RD_LAT=2, BASE_ADDR=0x8000_0000,
// DEPTH=4096). Table of write/read vectors with a scoreboard queue of
// expected read results, plus hand-written reset, abort and back-to-back
// sequences.
// ----------------------------------------------------------------------------
module tb_data_ram;

    localparam logic [63:0] BASE   = 64'h0000_0000_8000_0000;
    localparam int unsigned DEPTH  = 4096;
    localparam int unsigned RD_LAT = 2;
    localparam logic [63:0] ONES   = '1;

    typedef enum int {W_NONE, W_PRE, W_DURING} wmode_e;

    typedef struct {
        string       name;
        wmode_e      wmode;
        logic [63:0] waddr;
        logic [63:0] wdata;
        logic [63:0] wmask;
        logic        wr_err;
        logic [63:0] raddr;
        logic [63:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
    } sb_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_err;
    sb_t  sb_q [$];
    vec_t vecs [13];

    data_ram_if bus ();

    data_ram #(
        .BASE_ADDR (BASE),
        .DEPTH     (DEPTH),
        .RD_LAT    (RD_LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input wmode_e wmode,
                                input logic [63:0] waddr, input logic [63:0] wdata,
                                input logic [63:0] wmask, input logic wr_err,
                                input logic [63:0] raddr, input logic [63:0] exp_rdata,
                                input logic exp_err);
        vec_t v;
        v.name = name;   v.wmode = wmode;   v.waddr = waddr;
        v.wdata = wdata; v.wmask = wmask;   v.wr_err = wr_err;
        v.raddr = raddr; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single write cycle, then check the error pulse is one cycle wide.
    task automatic do_write(input string name, input logic [63:0] addr,
                            input logic [63:0] data, input logic [63:0] mask,
                            input logic exp_err);
        tick();
        bus.ram_ren_i   = 1'b0;
        bus.ram_wen_i   = 1'b1;
        bus.ram_waddr_i = addr;
        bus.ram_wdata_i = data;
        bus.ram_wmask_i = mask;
        tick();
        bus.ram_wen_i = 1'b0;
        @(negedge clk);
        check({name, "_werr"}, 64'(bus.ram_err_o), 64'(exp_err));
        tick();
        @(negedge clk);
        check({name, "_werr_end"}, 64'(bus.ram_err_o), 64'd0);
    endtask

    // Issue a read at cycle T, optionally write at T+1, wait for ready.
    task automatic do_read(input vec_t v);
        bit  done;
        sb_t exp;
        tick();
        bus.ram_ren_i   = 1'b1;
        bus.ram_raddr_i = v.raddr;
        sb_q.push_back('{rdata: v.exp_rdata, err: v.exp_err});
        done = 1'b0;
        for (int c = 0; c <= int'(RD_LAT) + 2 && !done; c++) begin
            if (c > 0) tick();
            bus.ram_wen_i = (v.wmode == W_DURING) && (c == 1);
            if (bus.ram_wen_i) begin
                bus.ram_waddr_i = v.waddr;
                bus.ram_wdata_i = v.wdata;
                bus.ram_wmask_i = v.wmask;
            end
            @(negedge clk);
            check({v.name, "_ready"}, 64'(bus.ram_ready_o), 64'(c == int'(RD_LAT)));
            if (bus.ram_ready_o) begin
                done = 1'b1;
                check({v.name, "_latency"}, 64'(c), 64'(RD_LAT));
                if (sb_q.size() == 0) begin
                    check({v.name, "_sb_empty"}, 64'd0, 64'd1);
                end else begin
                    exp = sb_q.pop_front();
                    check({v.name, "_rdata"}, bus.ram_rdata_o, exp.rdata);
                    check({v.name, "_err"}, 64'(bus.ram_err_o), 64'(exp.err));
                end
            end
        end
        if (!done) check({v.name, "_timeout"}, 64'd0, 64'd1);
        tick();
        bus.ram_ren_i = 1'b0;
        bus.ram_wen_i = 1'b0;
        @(negedge clk);
        check({v.name, "_idle_ready"}, 64'(bus.ram_ready_o), 64'd1);
        check({v.name, "_err_pulse"}, 64'(bus.ram_err_o), 64'd0);
        check({v.name, "_hold"}, bus.ram_rdata_o, v.exp_rdata);
    endtask

    initial begin
        n_checks = 0;
        n_err    = 0;
        rst      = 1'b0;
        bus.ram_ren_i   = 1'b0;
        bus.ram_raddr_i = '0;
        bus.ram_wen_i   = 1'b0;
        bus.ram_waddr_i = '0;
        bus.ram_wdata_i = '0;
        bus.ram_wmask_i = '0;

        vecs[0]  = mk("full_wr",    W_PRE,    64'h8000_0008, 64'h1122334455667788, ONES, 0,
                      64'h8000_0008, 64'h1122334455667788, 0);
        vecs[1]  = mk("byte_mask",  W_PRE,    64'h8000_000C, 64'hAAAAAAAAAAAAAAAA, 64'hFF, 0,
                      64'h8000_0008, 64'h11223344556677AA, 0);
        vecs[2]  = mk("fwd",        W_DURING, 64'h8000_0008, 64'hDEAD000000000000,
                      64'hFFFF000000000000, 0, 64'h8000_0008, 64'hDEAD3344556677AA, 0);
        vecs[3]  = mk("fwd_landed", W_NONE,   0, 0, 0, 0,
                      64'h8000_0008, 64'hDEAD3344556677AA, 0);
        vecs[4]  = mk("base_wr",    W_PRE,    64'h8000_0000, 64'h0123456789ABCDEF, ONES, 0,
                      64'h8000_0000, 64'h0123456789ABCDEF, 0);
        vecs[5]  = mk("rd_oor_low", W_NONE,   0, 0, 0, 0, 64'h0000_1000, 64'd0, 1);
        vecs[6]  = mk("wr_oor",     W_PRE,    64'h8000_8000, ONES, ONES, 1,
                      64'h8000_0000, 64'h0123456789ABCDEF, 0);
        vecs[7]  = mk("top_word",   W_PRE,    64'h8000_7FF8, 64'h5555555555555555, ONES, 0,
                      64'h8000_7FFF, 64'h5555555555555555, 0);
        vecs[8]  = mk("below_base", W_NONE,   0, 0, 0, 0, 64'h7FFF_FFF8, 64'd0, 1);
        vecs[9]  = mk("fwd_other",  W_DURING, 64'h8000_0010, 64'h0F0F0F0F0F0F0F0F, ONES, 0,
                      64'h8000_0000, 64'h0123456789ABCDEF, 0);
        vecs[10] = mk("other_land", W_NONE,   0, 0, 0, 0,
                      64'h8000_0010, 64'h0F0F0F0F0F0F0F0F, 0);
        vecs[11] = mk("bit_mask",   W_PRE,    64'h8000_0010, 64'd0, 64'h101, 0,
                      64'h8000_0010, 64'h0F0F0F0F0F0F0E0E, 0);
        vecs[12] = mk("dual_err",   W_DURING, 64'h9000_0000, ONES, ONES, 0,
                      64'h0000_0000, 64'd0, 1);

        // Reset state.
        repeat (3) tick();
        @(negedge clk);
        check("rst_ready", 64'(bus.ram_ready_o), 64'd1);
        check("rst_err",   64'(bus.ram_err_o),   64'd0);
        check("rst_rdata", bus.ram_rdata_o,      64'd0);
        tick();
        rst = 1'b1;

        foreach (vecs[i]) begin
            if (vecs[i].wmode == W_PRE)
                do_write(vecs[i].name, vecs[i].waddr, vecs[i].wdata,
                         vecs[i].wmask, vecs[i].wr_err);
            do_read(vecs[i]);
        end

        // Reset in WAIT: request discarded, rdata cleared, write ignored.
        tick();
        bus.ram_ren_i   = 1'b1;
        bus.ram_raddr_i = 64'h8000_0008;
        tick();
        rst = 1'b0;
        bus.ram_wen_i   = 1'b1;
        bus.ram_waddr_i = 64'h8000_0000;
        bus.ram_wdata_i = 64'd0;
        bus.ram_wmask_i = ONES;
        @(negedge clk);
        check("rstw_wait_ready", 64'(bus.ram_ready_o), 64'd0);
        tick();
        rst = 1'b1;
        bus.ram_wen_i = 1'b0;
        bus.ram_ren_i = 1'b0;
        @(negedge clk);
        check("rstw_ready", 64'(bus.ram_ready_o), 64'd1);
        check("rstw_rdata", bus.ram_rdata_o,      64'd0);
        check("rstw_err",   64'(bus.ram_err_o),   64'd0);

        // Abort: ren dropped in WAIT, no DONE, rdata stays 0.
        tick();
        bus.ram_ren_i   = 1'b1;
        bus.ram_raddr_i = 64'h8000_0008;
        tick();
        bus.ram_ren_i = 1'b0;
        @(negedge clk);
        check("abort_wait_ready", 64'(bus.ram_ready_o), 64'd0);
        for (int k = 0; k < 2; k++) begin
            tick();
            @(negedge clk);
            check("abort_ready", 64'(bus.ram_ready_o), 64'd1);
            check("abort_rdata", bus.ram_rdata_o,      64'd0);
            check("abort_err",   64'(bus.ram_err_o),   64'd0);
        end

        // Contents survive reset and the write issued under reset was dropped.
        do_read(mk("retained", W_NONE, 0, 0, 0, 0,
                   64'h8000_0000, 64'h0123456789ABCDEF, 0));

        // Back-to-back: ren stays high through DONE into a new request.
        tick();
        bus.ram_ren_i   = 1'b1;
        bus.ram_raddr_i = 64'h8000_0000;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) tick();
            if (c == 3) bus.ram_raddr_i = 64'h8000_0008;
            @(negedge clk);
            check("b2b_ready", 64'(bus.ram_ready_o), 64'(c == 2 || c == 5));
            if (c == 2) check("b2b_rdata_a", bus.ram_rdata_o, 64'h0123456789ABCDEF);
            if (c == 5) check("b2b_rdata_b", bus.ram_rdata_o, 64'hDEAD3344556677AA);
        end
        tick();
        bus.ram_ren_i = 1'b0;
        @(negedge clk);
        check("b2b_end_ready", 64'(bus.ram_ready_o), 64'd1);
        check("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
